// File: rtl/seven_segment_multi_display.sv
// rtl/seven_segment_multi_display.sv - multi-digit seven-segment driver with hex/decimal, blanking and blink
//
// Accepts an unsigned value through a valid/ready handshake and shows it on
// DIGITS active-low seven-segment digits, either as hex nibbles or as decimal
// produced by a sequential shift-add-3 binary-to-BCD conversion (one bit per
// cycle). Values that do not fit are shown as all dashes. Optional leading-zero
// blanking and a free-running blink gate on the output.
//
// Ports:
//   clk            single clock, rising edge
//   reset          synchronous, active-high
//   load_valid     new value offered
//   load_ready     high only while idle; value accepted when both are high
//   load_data      unsigned value to display
//   mode_decimal   1 = decimal, 0 = hex (sampled at accept)
//   suppress_zeros leading-zero blanking (sampled at accept)
//   blink_enable   live blink gate
//   segments       registered, active-low; digit k at [7k+6:7k], bits g..a
module seven_segment_multi_display #(
    parameter int DIGITS     = 6,
    parameter int DATA_WIDTH = 20,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [DATA_WIDTH-1:0]   load_data,
    input  logic                    mode_decimal,
    input  logic                    suppress_zeros,
    input  logic                    blink_enable,
    output logic [7*DIGITS-1:0]     segments
);

    // floor(DATA_WIDTH*log10(2))+1 decimal digits; *3/10 is exact for widths up to 32
    localparam int BCD_DIGITS = (DATA_WIDTH * 3) / 10 + 1;
    localparam int HEX_DIGITS = (DATA_WIDTH + 3) / 4;
    localparam int SRC_DIGITS = (BCD_DIGITS > HEX_DIGITS)
                              ? ((BCD_DIGITS > DIGITS) ? BCD_DIGITS : DIGITS)
                              : ((HEX_DIGITS > DIGITS) ? HEX_DIGITS : DIGITS);
    localparam int SRC_W      = 4 * SRC_DIGITS;
    localparam int CNT_W      = $clog2(DATA_WIDTH + 1);
    localparam int BLINK_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CONVERT = 2'd1;
    localparam logic [1:0] S_UPDATE  = 2'd2;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    logic [1:0]                state_q, state_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic [4*BCD_DIGITS-1:0]   bcd_q, bcd_d;
    logic [4*BCD_DIGITS-1:0]   bcd_adj;
    logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
    logic                      mode_dec_q, mode_dec_d;
    logic                      suppress_q, suppress_d;
    logic [7*DIGITS-1:0]       disp_q, disp_d;
    logic [7*DIGITS-1:0]       disp_new;
    logic [7*DIGITS-1:0]       seg_q, seg_d;
    logic [BLINK_W-1:0]        blink_cnt_q, blink_cnt_d;
    logic                      phase_on_q, phase_on_d;

    logic [SRC_W-1:0]          src_vec;
    logic                      overflow;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0011000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    // Add-3 correction applied before every shift of the double-dabble.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Both sources widened to a common digit count so overflow can look past DIGITS.
    assign src_vec = mode_dec_q ? SRC_W'(bcd_q) : SRC_W'(data_q);

    always_comb begin : render
        logic leading;
        overflow = 1'b0;
        for (int i = DIGITS; i < SRC_DIGITS; i++) begin
            if (src_vec[4*i +: 4] != 4'h0) begin
                overflow = 1'b1;
            end
        end
        disp_new = '1;
        leading  = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (src_vec[4*k +: 4] != 4'h0) begin
                leading = 1'b0;
            end
            if (overflow) begin
                disp_new[7*k +: 7] = SEG_DASH;
            end else if (suppress_q && leading && (k != 0)) begin
                disp_new[7*k +: 7] = SEG_BLANK;
            end else begin
                disp_new[7*k +: 7] = glyph(src_vec[4*k +: 4]);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        bcd_d      = bcd_q;
        bit_cnt_d  = bit_cnt_q;
        mode_dec_d = mode_dec_q;
        suppress_d = suppress_q;
        disp_d     = disp_q;
        case (state_q)
            S_IDLE: begin
                if (load_valid) begin
                    data_d     = load_data;
                    bcd_d      = '0;
                    bit_cnt_d  = '0;
                    mode_dec_d = mode_decimal;
                    suppress_d = suppress_zeros;
                    state_d    = mode_decimal ? S_CONVERT : S_UPDATE;
                end
            end
            S_CONVERT: begin
                bcd_d     = {bcd_adj[4*BCD_DIGITS-2:0], data_q[DATA_WIDTH-1]};
                data_d    = data_q << 1;
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                disp_d  = disp_new;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Blink gate works from next-state values so the output register never
    // adds latency to a display update or to a blink_enable change.
    always_comb begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        phase_on_d  = phase_on_q;
        if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            phase_on_d  = ~phase_on_q;
        end
        seg_d = (blink_enable && !phase_on_d) ? '1 : disp_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            data_q      <= '0;
            bcd_q       <= '0;
            bit_cnt_q   <= '0;
            mode_dec_q  <= 1'b0;
            suppress_q  <= 1'b0;
            disp_q      <= '1;
            seg_q       <= '1;
            blink_cnt_q <= '0;
            phase_on_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            bcd_q       <= bcd_d;
            bit_cnt_q   <= bit_cnt_d;
            mode_dec_q  <= mode_dec_d;
            suppress_q  <= suppress_d;
            disp_q      <= disp_d;
            seg_q       <= seg_d;
            blink_cnt_q <= blink_cnt_d;
            phase_on_q  <= phase_on_d;
        end
    end

    assign load_ready = (state_q == S_IDLE);
    assign segments   = seg_q;

endmodule

// File: tb/tb_seven_segment_multi_display.sv
// tb/tb_seven_segment_multi_display.sv - self-checking bench for seven_segment_multi_display
module tb_seven_segment_multi_display;

    localparam int DW = 20;
    localparam int BD = 4;
    localparam logic [41:0] ONES = {42{1'b1}};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [19:0] load_data = '0;
    logic        mode_decimal = 1'b0;
    logic        suppress_zeros = 1'b0;
    logic        blink_enable = 1'b0;
    logic [41:0] segments;

    int n_vec = 0;
    int n_err = 0;

    seven_segment_multi_display #(
        .DIGITS(6), .DATA_WIDTH(DW), .BLINK_DIV(BD)
    ) dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .mode_decimal(mode_decimal),
        .suppress_zeros(suppress_zeros), .blink_enable(blink_enable),
        .segments(segments)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Display image straight from positional arithmetic on the value.
    function automatic logic [41:0] disp_of(input longint v, input bit dec, input bit sup);
        longint base, p;
        logic [41:0] r;
        base = dec ? 10 : 16;
        p = 1;
        for (int k = 0; k < 6; k++) p = p * base;
        if (v >= p) return {6{7'b0111111}};
        p = 1;
        for (int k = 0; k < 6; k++) begin
            if (sup && k > 0 && v < p) r[7*k +: 7] = 7'b1111111;
            else r[7*k +: 7] = glyph_tab[int'((v / p) % base)];
            p = p * base;
        end
        return r;
    endfunction

    // Model state: remaining cycles until the pending image is shown.
    bit          model_on = 1'b0;
    int          busy = 0;
    int          bcnt = 0;
    bit          phase_on = 1'b1;
    logic [41:0] disp_m = ONES;
    logic [41:0] pend_m = ONES;
    logic [41:0] exp_seg = ONES;
    bit          exp_ready = 1'b1;

    task automatic model_step();
        if (reset) begin
            busy = 0; bcnt = 0; phase_on = 1'b1; disp_m = ONES; exp_seg = ONES;
            model_on = 1'b1;
        end else begin
            if (bcnt == BD - 1) begin bcnt = 0; phase_on = !phase_on; end
            else bcnt++;
            if (busy > 0) begin
                busy--;
                if (busy == 0) disp_m = pend_m;
            end else if (load_valid) begin
                pend_m = disp_of(longint'(load_data), mode_decimal, suppress_zeros);
                busy = mode_decimal ? DW + 1 : 1;
            end
            exp_seg = (blink_enable && !phase_on) ? ONES : disp_m;
        end
        exp_ready = (busy == 0);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (model_on) begin
            n_vec++;
            if (load_ready !== exp_ready) begin
                n_err++;
                $display("FAIL load_ready @%0t: got %b expected %b", $time, load_ready, exp_ready);
            end
            n_vec++;
            if (segments !== exp_seg) begin
                n_err++;
                $display("FAIL segments @%0t: got %h expected %h", $time, segments, exp_seg);
            end
        end
    end

    task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [19:0] v, input bit dec, input bit sup,
                           input int lat, input bit chk, input logic [41:0] exp_s,
                           input string name);
        int n;
        @(negedge clk);
        lit({name, " ready_before"}, 64'(load_ready), 64'd1);
        load_valid = 1'b1; load_data = v; mode_decimal = dec; suppress_zeros = sup;
        @(negedge clk);
        load_valid = 1'b0;
        n = 1;
        while (!load_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        lit({name, " latency"}, 64'(n), 64'(lat));
        if (chk) lit({name, " segments"}, 64'(segments), 64'(exp_s));
    endtask

    localparam logic [41:0] E_2A   = {{4{7'b1000000}}, 7'b0100100, 7'b0001000};
    localparam logic [41:0] E_123K = {7'b1111001, 7'b0100100, 7'b0110000,
                                      7'b0011001, 7'b0010010, 7'b0000010};
    localparam logic [41:0] E_DASH = {6{7'b0111111}};
    localparam logic [41:0] E_Z    = {{5{7'b1111111}}, 7'b1000000};
    localparam logic [41:0] E_F0   = {{4{7'b1111111}}, 7'b0001110, 7'b1000000};

    initial begin : main
        logic [41:0] s [16];
        int n;
        int ones_cnt;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        lit("reset_segments", 64'(segments), 64'(ONES));
        lit("reset_ready", 64'(load_ready), 64'd1);

        lit("model_2a", 64'(disp_of(42, 0, 0)), 64'(E_2A));
        lit("model_dash", 64'(disp_of(1000000, 1, 0)), 64'(E_DASH));

        do_load(20'h0002A, 0, 0, 2, 1, E_2A, "hex_2a");
        do_load(20'd123456, 1, 0, DW + 2, 1, E_123K, "dec_123456");
        do_load(20'd1000000, 1, 0, DW + 2, 1, E_DASH, "dec_overflow");
        do_load(20'd0, 1, 1, DW + 2, 1, E_Z, "dec_zero_sup");
        do_load(20'h000F0, 0, 1, 2, 1, E_F0, "hex_f0_sup");
        do_load(20'hFFFFF, 0, 0, 2, 0, '0, "hex_fffff");
        do_load(20'h00001, 0, 1, 2, 0, '0, "hex_1_sup");
        do_load(20'd999999, 1, 1, DW + 2, 0, '0, "dec_999999");
        do_load(20'hFFFFF, 1, 0, DW + 2, 0, '0, "dec_max");
        do_load(20'd100, 1, 1, DW + 2, 0, '0, "dec_100_sup");
        do_load(20'h0B0C0, 0, 1, 2, 0, '0, "hex_b0c0_sup");

        // load_valid held through CONVERT with a different value offered
        @(negedge clk);
        load_valid = 1'b1; load_data = 20'd123456; mode_decimal = 1'b1; suppress_zeros = 1'b0;
        @(negedge clk);
        load_data = 20'd5;
        repeat (10) @(negedge clk);
        load_valid = 1'b0;
        n = 11;
        while (!load_ready && n < 100) begin @(negedge clk); n++; end
        lit("held_valid latency", 64'(n), 64'(DW + 2));
        lit("held_valid segments", 64'(segments), 64'(E_123K));

        // reset in the middle of a conversion
        @(negedge clk);
        load_valid = 1'b1; load_data = 20'd777; mode_decimal = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        lit("midreset ready", 64'(load_ready), 64'd1);
        lit("midreset segments", 64'(segments), 64'(ONES));
        repeat (30) @(negedge clk);
        lit("midreset never_shown", 64'(segments), 64'(ONES));

        // blink
        do_load(20'h0002A, 0, 0, 2, 1, E_2A, "hex_2a_again");
        blink_enable = 1'b1;
        ones_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            s[i] = segments;
            if (segments === ONES) ones_cnt++;
        end
        lit("blink ones_count", 64'(ones_cnt), 64'd8);
        for (int i = 4; i < 16; i++)
            lit("blink alternation", 64'(s[i] === ONES), 64'(s[i-4] !== ONES));
        n = 0;
        while (segments !== ONES && n < 10) begin @(negedge clk); n++; end
        lit("blink off_found", 64'(segments === ONES), 64'd1);
        blink_enable = 1'b0;
        @(negedge clk);
        lit("blink restore", 64'(segments), 64'(E_2A));
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
